// File: rtl/div_pkg.sv
// Shared definitions for the divider-sharing arbiter.
// Holds the default divider latency and operand width, and the tag type that
// travels alongside each issued division so its result can be routed back to
// the requester that issued it.
package div_pkg;

  localparam int DIV_LATENCY_DEFAULT = 11;
  localparam int WIDTH_DEFAULT       = 64;

  // Fixed tag index width; supports up to 256 requesters.
  localparam int TAG_IDX_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] index;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, purely combinational.
// Ports:
//   i_req   - request vector, one bit per requester
//   i_ptr   - index of the most recently granted requester; the search
//             starts one position above it and wraps
//   o_grant - one-hot grant, all zero when no request is set
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant
);

  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_pipe_arbiter.sv
// Shares one pipelined divider among NUM_REQ requesters.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   req_valid / req_ready       - per-requester handshake (ready is the
//                                 combinational one-hot grant)
//   req_dividend / req_divisor  - packed operands, slice i for requester i
//   hold                        - blocks new accepts only
//   div_start / div_dividend /
//   div_divisor                 - issue port to the divider
//   div_data_valid /
//   div_quotient / div_by_zero  - divider result port
//   rsp_valid                   - one-hot result strobe
//   rsp_quotient /
//   rsp_div_by_zero             - shared result bus
//   err_sync                    - sticky tag/result misalignment flag
module div_pipe_arbiter
  import div_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT,
  parameter int MAX_OUT     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
  input  logic                     hold,
  output logic                     div_start,
  output logic [WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  input  logic                     div_data_valid,
  input  logic [WIDTH-1:0]         div_quotient,
  input  logic                     div_by_zero,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_quotient,
  output logic                     rsp_div_by_zero,
  output logic                     err_sync
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [IDX_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]   r_out_cnt [NUM_REQ];
  logic               r_div_start;
  logic [WIDTH-1:0]   r_div_dividend;
  logic [WIDTH-1:0]   r_div_divisor;
  logic [IDX_W-1:0]   r_issue_idx;
  tag_t               r_tag [DIV_LATENCY];
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_quotient;
  logic               r_rsp_div_by_zero;
  logic               r_err_sync;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_xfer;
  logic [IDX_W-1:0]   w_gidx;
  logic [WIDTH-1:0]   w_sel_dvd;
  logic [WIDTH-1:0]   w_sel_dvs;
  tag_t               w_exit;
  logic               w_rsp_fire;
  logic               w_mismatch;
  logic [NUM_REQ-1:0] w_rsp_onehot;

  // A requester at its credit limit is let back in during the same cycle its
  // response strobe is out, since that strobe is what frees the credit.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = req_valid[i] & ~hold & ~rst &
                  ((r_out_cnt[i] < CNT_W'(MAX_OUT)) | r_rsp_valid[i]);
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req   (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant)
  );

  assign req_ready = w_grant;
  assign w_xfer    = |w_grant;

  always_comb begin
    w_gidx    = '0;
    w_sel_dvd = '0;
    w_sel_dvs = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gidx    = IDX_W'(i);
        w_sel_dvd = req_dividend[i*WIDTH +: WIDTH];
        w_sel_dvs = req_divisor[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_exit     = r_tag[DIV_LATENCY-1];
  assign w_rsp_fire = div_data_valid & w_exit.valid;
  assign w_mismatch = div_data_valid ^ w_exit.valid;

  always_comb begin
    w_rsp_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rsp_onehot[i] = w_rsp_fire && (w_exit.index == TAG_IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr          <= IDX_W'(NUM_REQ - 1);
      r_div_start       <= 1'b0;
      r_div_dividend    <= '0;
      r_div_divisor     <= '0;
      r_issue_idx       <= '0;
      r_rsp_valid       <= '0;
      r_rsp_quotient    <= '0;
      r_rsp_div_by_zero <= 1'b0;
      r_err_sync        <= 1'b0;
      for (int k = 0; k < DIV_LATENCY; k++) r_tag[k] <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_out_cnt[i] <= '0;
    end else begin
      // Accept -> issue register
      r_div_start <= w_xfer;
      if (w_xfer) begin
        r_rr_ptr       <= w_gidx;
        r_issue_idx    <= w_gidx;
        r_div_dividend <= w_sel_dvd;
        r_div_divisor  <= w_sel_dvs;
      end

      // Issue -> tag pipeline; the tag shadows the divider so its exit lines
      // up with div_data_valid
      r_tag[0] <= '{valid: r_div_start, index: TAG_IDX_W'(r_issue_idx)};
      for (int k = 1; k < DIV_LATENCY; k++) r_tag[k] <= r_tag[k-1];

      // Divider result -> response register
      r_rsp_valid <= w_rsp_onehot;
      if (w_rsp_fire) begin
        r_rsp_quotient    <= div_quotient;
        r_rsp_div_by_zero <= div_by_zero;
      end
      if (w_mismatch) r_err_sync <= 1'b1;

      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i] && !r_rsp_valid[i])
          r_out_cnt[i] <= r_out_cnt[i] + CNT_W'(1);
        else if (!w_grant[i] && r_rsp_valid[i])
          r_out_cnt[i] <= r_out_cnt[i] - CNT_W'(1);
      end
    end
  end

  assign div_start       = r_div_start;
  assign div_dividend    = r_div_dividend;
  assign div_divisor     = r_div_divisor;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_quotient    = r_rsp_quotient;
  assign rsp_div_by_zero = r_rsp_div_by_zero;
  assign err_sync        = r_err_sync;

endmodule

// File: tb/tb_div_pipe_arbiter.sv
// Testbench for div_pipe_arbiter: a behavioural divider with fixed latency,
// directed phases plus a randomized phase, and a reference model that tracks
// credits, round-robin order and an ordered queue of expected responses.
module tb_div_pipe_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int L  = 11;
  localparam int MO = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_dividend = '0;
  logic [N*W-1:0]   req_divisor = '0;
  logic             hold = 1'b0;
  logic             div_start;
  logic [W-1:0]     div_dividend;
  logic [W-1:0]     div_divisor;
  logic             div_data_valid;
  logic [W-1:0]     div_quotient;
  logic             div_by_zero;
  logic [N-1:0]     rsp_valid;
  logic [W-1:0]     rsp_quotient;
  logic             rsp_div_by_zero;
  logic             err_sync;
  logic             inj_dv = 1'b0;

  int ncomp = 0;
  int nfail = 0;
  int cyc   = 0;

  div_pipe_arbiter #(
    .NUM_REQ(N), .WIDTH(W), .DIV_LATENCY(L), .MAX_OUT(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .hold(hold),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_data_valid(div_data_valid), .div_quotient(div_quotient), .div_by_zero(div_by_zero),
    .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient), .rsp_div_by_zero(rsp_div_by_zero),
    .err_sync(err_sync)
  );

  always #5 clk = ~clk;

  // Behavioural divider: result appears L cycles after div_start; divide by
  // zero returns all ones with the flag set. Reset together with the DUT.
  logic         dv_v [L];
  logic [W-1:0] dv_q [L];
  logic         dv_z [L];

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < L; k++) dv_v[k] <= 1'b0;
    end else begin
      dv_v[0] <= div_start;
      dv_q[0] <= (div_divisor == '0) ? '1 : div_dividend / div_divisor;
      dv_z[0] <= (div_divisor == '0);
      for (int k = 1; k < L; k++) begin
        dv_v[k] <= dv_v[k-1];
        dv_q[k] <= dv_q[k-1];
        dv_z[k] <= dv_z[k-1];
      end
    end
  end

  assign div_data_valid = dv_v[L-1] | inj_dv;
  assign div_quotient   = dv_q[L-1];
  assign div_by_zero    = dv_z[L-1];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct {
    int       idx;
    logic [W-1:0] q;
    logic     z;
    int       due;
  } exp_t;

  exp_t         sb[$];
  int           cnt [N];
  int           last = N - 1;
  bit           pend_start = 1'b0;
  logic [W-1:0] pend_dvd, pend_dvs;
  bit           exp_err = 1'b0;

  always @(negedge clk) begin
    exp_t         e;
    logic [N-1:0] exp_rsp;
    logic [N-1:0] exp_rdy;
    bit           tagv;
    int           g;
    int           i;
    logic [W-1:0] dvd, dvs;
    cyc++;
    if (rst) begin
      chk("ready_in_reset", W'(req_ready), '0);
      for (int k = 0; k < N; k++) cnt[k] = 0;
      last = N - 1;
      sb.delete();
      pend_start = 1'b0;
      exp_err = 1'b0;
    end else begin
      exp_rsp = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        exp_rsp[e.idx] = 1'b1;
        cnt[e.idx]--;
        chk("rsp_quotient", rsp_quotient, e.q);
        chk("rsp_div_by_zero", W'(rsp_div_by_zero), W'(e.z));
      end
      chk("rsp_valid", W'(rsp_valid), W'(exp_rsp));
      chk("div_start", W'(div_start), W'(pend_start));
      if (pend_start) begin
        chk("div_dividend", div_dividend, pend_dvd);
        chk("div_divisor", div_divisor, pend_dvs);
      end
      chk("err_sync", W'(err_sync), W'(exp_err));

      // A result is legitimately expected one cycle before its response is due.
      tagv = 1'b0;
      foreach (sb[j]) if (sb[j].due == cyc + 1) tagv = 1'b1;
      if (div_data_valid !== tagv) exp_err = 1'b1;

      g = -1;
      for (int k = 1; k <= N; k++) begin
        i = (last + k) % N;
        if (g < 0 && req_valid[i] && !hold && cnt[i] < MO) g = i;
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", W'(req_ready), W'(exp_rdy));

      pend_start = (g >= 0);
      if (g >= 0) begin
        dvd = req_dividend[g*W +: W];
        dvs = req_divisor[g*W +: W];
        last = g;
        cnt[g]++;
        pend_dvd = dvd;
        pend_dvs = dvs;
        sb.push_back('{idx: g, q: (dvs == '0) ? '1 : dvd / dvs, z: (dvs == '0), due: cyc + L + 2});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    req_dividend[i*W +: W] = dvd;
    req_divisor[i*W +: W]  = dvs;
  endtask

  function automatic logic [W-1:0] rnd_dvd();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [W-1:0] rnd_dvs();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1, 2:    v = {$urandom, $urandom};
      default: v = W'($urandom_range(1, 5000));
    endcase
    return v;
  endfunction

  initial begin
    // Reset with all requesters asking: nothing may be granted
    rst = 1'b1;
    req_valid = '1;
    tick(3);
    rst = 1'b0;
    req_valid = '0;
    #1;
    chk("div_dividend_reset", div_dividend, '0);
    chk("div_divisor_reset", div_divisor, '0);
    chk("rsp_quotient_reset", rsp_quotient, '0);
    chk("rsp_dbz_reset", W'(rsp_div_by_zero), '0);
    tick(2);

    // Single operation 100/7 from requester 0
    set_op(0, 64'd100, 64'd7);
    req_valid = 4'b0001;
    tick(1);
    req_valid = '0;
    tick(16);

    // Fairness: everyone valid continuously
    req_valid = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      for (int r = 0; r < N; r++) set_op(r, rnd_dvd(), rnd_dvs());
      tick(1);
    end
    req_valid = '0;
    tick(16);

    // Credit limit on requester 2
    req_valid = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      set_op(2, rnd_dvd(), W'($urandom_range(1, 100)));
      tick(1);
    end
    req_valid = '0;
    tick(16);

    // Divide by zero from requester 1
    set_op(1, 64'd12345, 64'd0);
    req_valid = 4'b0010;
    tick(1);
    req_valid = '0;
    tick(16);

    // Result with nothing in flight, then reset with ops in flight
    inj_dv = 1'b1;
    tick(1);
    inj_dv = 1'b0;
    tick(3);
    for (int r = 0; r < 3; r++) set_op(r, rnd_dvd(), rnd_dvs());
    req_valid = 4'b0111;
    tick(3);
    req_valid = '0;
    tick(2);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(20);

    // Hold blocks requester 3 while earlier ops still complete
    set_op(0, 64'd999, 64'd3);
    req_valid = 4'b0001;
    tick(2);
    hold = 1'b1;
    set_op(3, 64'd81, 64'd9);
    req_valid = 4'b1000;
    tick(16);
    hold = 1'b0;
    tick(1);
    req_valid = '0;
    tick(16);

    // Randomized traffic
    for (int c = 0; c < 300; c++) begin
      req_valid = N'($urandom_range(0, 15));
      hold = ($urandom_range(0, 9) == 0);
      for (int r = 0; r < N; r++) set_op(r, rnd_dvd(), rnd_dvs());
      tick(1);
    end
    req_valid = '0;
    hold = 1'b0;
    tick(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
